// File: rtl/isp_pkg.sv
// Shared definitions for the ISP parameter controller: register map, FSM encoding, defaults.
package isp_pkg;

    localparam int unsigned DATA_W      = 8;
    localparam int unsigned ADDR_W      = 4;
    localparam int unsigned RDATA_W     = 16;
    localparam int unsigned BYP_W       = 6;
    localparam int unsigned STATE_W     = 3;
    localparam int unsigned FRAME_CNT_W = 16;
    localparam int unsigned ERR_CNT_W   = 8;
    localparam int unsigned TO_CNT_W    = 24;

    // Stage defaults, also used by the standalone stage modules
    localparam logic [DATA_W-1:0] DEF_BLC   = 8'd50;
    localparam logic [DATA_W-1:0] DEF_GAMMA = 8'd22;
    localparam logic [DATA_W-1:0] DEF_SAT   = 8'd130;
    localparam logic [DATA_W-1:0] DEF_CON   = 8'd140;
    localparam logic [DATA_W-1:0] DEF_BADD  = 8'd5;
    localparam logic [DATA_W-1:0] DEF_BSUB  = 8'd0;

    // Register map
    localparam logic [ADDR_W-1:0] ADDR_BLC0      = 4'h0;
    localparam logic [ADDR_W-1:0] ADDR_BLC1      = 4'h1;
    localparam logic [ADDR_W-1:0] ADDR_BLC2      = 4'h2;
    localparam logic [ADDR_W-1:0] ADDR_BLC3      = 4'h3;
    localparam logic [ADDR_W-1:0] ADDR_GAMMA     = 4'h4;
    localparam logic [ADDR_W-1:0] ADDR_SAT       = 4'h5;
    localparam logic [ADDR_W-1:0] ADDR_CON       = 4'h6;
    localparam logic [ADDR_W-1:0] ADDR_BADD      = 4'h7;
    localparam logic [ADDR_W-1:0] ADDR_BSUB      = 4'h8;
    localparam logic [ADDR_W-1:0] ADDR_BYPASS    = 4'h9;
    localparam logic [ADDR_W-1:0] ADDR_COMMIT    = 4'hA;
    localparam logic [ADDR_W-1:0] ADDR_FRAME_CNT = 4'hB;
    localparam logic [ADDR_W-1:0] ADDR_STATUS    = 4'hC;

    // Frame tracker state encoding (visible in the status register)
    localparam logic [STATE_W-1:0] ST_IDLE  = 3'd0;
    localparam logic [STATE_W-1:0] ST_FRAME = 3'd1;
    localparam logic [STATE_W-1:0] ST_BLANK = 3'd2;

    // One complete tuning parameter set (shadow or active)
    typedef struct packed {
        logic [DATA_W-1:0] blc3;
        logic [DATA_W-1:0] blc2;
        logic [DATA_W-1:0] blc1;
        logic [DATA_W-1:0] blc0;
        logic [DATA_W-1:0] gamma;
        logic [DATA_W-1:0] sat;
        logic [DATA_W-1:0] con;
        logic [DATA_W-1:0] badd;
        logic [DATA_W-1:0] bsub;
        logic [BYP_W-1:0]  bypass;
    } isp_params_t;

    localparam isp_params_t PARAMS_DEF = '{
        blc3:   DEF_BLC,
        blc2:   DEF_BLC,
        blc1:   DEF_BLC,
        blc0:   DEF_BLC,
        gamma:  DEF_GAMMA,
        sat:    DEF_SAT,
        con:    DEF_CON,
        badd:   DEF_BADD,
        bsub:   DEF_BSUB,
        bypass: '0
    };

    // Zero-extend an 8-bit register to the read-data width
    function automatic logic [RDATA_W-1:0] zext8(input logic [DATA_W-1:0] v);
        return {8'h00, v};
    endfunction

endpackage

// File: rtl/isp_frame_tracker.sv
// Tracks frame structure from the monitored AXI4-Stream handshake: FSM, line/frame/timeout/error counters.
module isp_frame_tracker
    import isp_pkg::*;
#(
    parameter int unsigned IMG_HEIGHT = 1080,
    parameter int unsigned TIMEOUT    = 4_000_000
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   mon_tvalid,
    input  logic                   mon_tready,
    input  logic                   mon_tuser,
    input  logic                   mon_tlast,
    output logic [STATE_W-1:0]     state,
    output logic [FRAME_CNT_W-1:0] frame_cnt,
    output logic [ERR_CNT_W-1:0]   err_cnt,
    output logic                   boundary_ok
);

    localparam int unsigned LINE_W = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
    localparam logic [LINE_W-1:0]   LINE_LAST = LINE_W'(IMG_HEIGHT - 1);
    localparam logic [TO_CNT_W-1:0] TO_LAST   = TO_CNT_W'(TIMEOUT - 1);

    logic                beat;
    logic                sof;
    logic                eol;
    logic [STATE_W-1:0]  state_nxt;
    logic [LINE_W-1:0]   line_cnt;
    logic [LINE_W-1:0]   line_nxt;
    logic [LINE_W-1:0]   line_base;
    logic [LINE_W-1:0]   line_adv;
    logic                line_done;
    logic [TO_CNT_W-1:0] to_cnt;
    logic [TO_CNT_W-1:0] to_nxt;
    logic                frame_inc;
    logic                err_inc;

    assign beat = mon_tvalid & mon_tready;
    assign sof  = beat & mon_tuser;
    assign eol  = beat & mon_tlast;

    // Next state and counter updates; an SOF beat restarts line counting at line 0
    always_comb begin
        state_nxt = state;
        line_nxt  = line_cnt;
        to_nxt    = '0;
        frame_inc = 1'b0;
        err_inc   = 1'b0;
        line_base = sof ? '0 : line_cnt;
        line_done = eol && (line_base == LINE_LAST);
        if (line_done) begin
            line_adv = '0;
        end else if (eol) begin
            line_adv = line_base + LINE_W'(1);
        end else begin
            line_adv = line_base;
        end

        case (state)
            ST_IDLE, ST_BLANK: begin
                if (sof) begin
                    line_nxt  = line_adv;
                    state_nxt = line_done ? ST_BLANK : ST_FRAME;
                    frame_inc = line_done;
                end else if (beat && (state == ST_BLANK)) begin
                    err_inc = 1'b1;
                end
            end
            ST_FRAME: begin
                if (beat) begin
                    err_inc  = sof;
                    line_nxt = line_adv;
                    if (line_done) begin
                        state_nxt = ST_BLANK;
                        frame_inc = 1'b1;
                    end
                end else if (to_cnt == TO_LAST) begin
                    err_inc   = 1'b1;
                    state_nxt = ST_IDLE;
                    line_nxt  = '0;
                end else begin
                    to_nxt = to_cnt + TO_CNT_W'(1);
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                line_nxt  = '0;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Counters and the commit window flag (IDLE, or first cycle of BLANK)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            line_cnt    <= '0;
            to_cnt      <= '0;
            frame_cnt   <= '0;
            err_cnt     <= '0;
            boundary_ok <= 1'b1;
        end else begin
            line_cnt    <= line_nxt;
            to_cnt      <= to_nxt;
            if (frame_inc) begin
                frame_cnt <= frame_cnt + FRAME_CNT_W'(1);
            end
            if (err_inc && (err_cnt != {ERR_CNT_W{1'b1}})) begin
                err_cnt <= err_cnt + ERR_CNT_W'(1);
            end
            boundary_ok <= (state_nxt == ST_IDLE) ||
                           ((state_nxt == ST_BLANK) && (state != ST_BLANK));
        end
    end

endmodule

// File: rtl/isp_param_ctrl.sv
// Runtime ISP tuning controller: shadow/active register banks with frame-boundary commit.
module isp_param_ctrl
    import isp_pkg::*;
#(
    parameter int unsigned IMG_HEIGHT = 1080,
    parameter int unsigned TIMEOUT    = 4_000_000
) (
    input  logic                   I_clk,
    input  logic                   I_rst_n,
    input  logic                   cfg_wr_en,
    input  logic                   cfg_rd_en,
    input  logic [ADDR_W-1:0]      cfg_addr,
    input  logic [DATA_W-1:0]      cfg_wdata,
    output logic [RDATA_W-1:0]     cfg_rdata,
    output logic                   cfg_rd_valid,
    input  logic                   mon_tvalid,
    input  logic                   mon_tready,
    input  logic                   mon_tuser,
    input  logic                   mon_tlast,
    output logic [4*DATA_W-1:0]    O_blc_offset,
    output logic [DATA_W-1:0]      O_gamma_10x,
    output logic [DATA_W-1:0]      O_sat_val,
    output logic [DATA_W-1:0]      O_contrast,
    output logic [DATA_W-1:0]      O_bright_add,
    output logic [DATA_W-1:0]      O_bright_minus,
    output logic [BYP_W-1:0]       O_bypass,
    output logic                   O_param_update,
    output logic [FRAME_CNT_W-1:0] O_frame_cnt,
    output logic [ERR_CNT_W-1:0]   O_err_cnt
);

    isp_params_t           shadow;
    isp_params_t           shadow_nxt;
    isp_params_t           active;
    logic                  commit_pend;
    logic                  commit_wr;
    logic                  apply;
    logic                  boundary_ok;
    logic [STATE_W-1:0]    state;
    logic [RDATA_W-1:0]    rd_mux;

    isp_frame_tracker #(
        .IMG_HEIGHT (IMG_HEIGHT),
        .TIMEOUT    (TIMEOUT)
    ) u_tracker (
        .clk         (I_clk),
        .rst_n       (I_rst_n),
        .mon_tvalid  (mon_tvalid),
        .mon_tready  (mon_tready),
        .mon_tuser   (mon_tuser),
        .mon_tlast   (mon_tlast),
        .state       (state),
        .frame_cnt   (O_frame_cnt),
        .err_cnt     (O_err_cnt),
        .boundary_ok (boundary_ok)
    );

    assign commit_wr = cfg_wr_en && (cfg_addr == ADDR_COMMIT);
    assign apply     = commit_pend && boundary_ok;

    // Host write decode into the shadow bank
    always_comb begin
        shadow_nxt = shadow;
        if (cfg_wr_en) begin
            case (cfg_addr)
                ADDR_BLC0:   shadow_nxt.blc0   = cfg_wdata;
                ADDR_BLC1:   shadow_nxt.blc1   = cfg_wdata;
                ADDR_BLC2:   shadow_nxt.blc2   = cfg_wdata;
                ADDR_BLC3:   shadow_nxt.blc3   = cfg_wdata;
                ADDR_GAMMA:  shadow_nxt.gamma  = cfg_wdata;
                ADDR_SAT:    shadow_nxt.sat    = cfg_wdata;
                ADDR_CON:    shadow_nxt.con    = cfg_wdata;
                ADDR_BADD:   shadow_nxt.badd   = cfg_wdata;
                ADDR_BSUB:   shadow_nxt.bsub   = cfg_wdata;
                ADDR_BYPASS: shadow_nxt.bypass = cfg_wdata[BYP_W-1:0];
                default:     shadow_nxt        = shadow;
            endcase
        end
    end

    // Read mux over current (pre-write) register contents
    always_comb begin
        rd_mux = '0;
        case (cfg_addr)
            ADDR_BLC0:      rd_mux = zext8(shadow.blc0);
            ADDR_BLC1:      rd_mux = zext8(shadow.blc1);
            ADDR_BLC2:      rd_mux = zext8(shadow.blc2);
            ADDR_BLC3:      rd_mux = zext8(shadow.blc3);
            ADDR_GAMMA:     rd_mux = zext8(shadow.gamma);
            ADDR_SAT:       rd_mux = zext8(shadow.sat);
            ADDR_CON:       rd_mux = zext8(shadow.con);
            ADDR_BADD:      rd_mux = zext8(shadow.badd);
            ADDR_BSUB:      rd_mux = zext8(shadow.bsub);
            ADDR_BYPASS:    rd_mux = RDATA_W'(shadow.bypass);
            ADDR_COMMIT:    rd_mux = RDATA_W'(commit_pend);
            ADDR_FRAME_CNT: rd_mux = O_frame_cnt;
            ADDR_STATUS:    rd_mux = {O_err_cnt, 5'b0, state};
            default:        rd_mux = '0;
        endcase
    end

    // Shadow bank, active bank and commit handshake; the apply copies the pre-write shadow
    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            shadow         <= PARAMS_DEF;
            active         <= PARAMS_DEF;
            commit_pend    <= 1'b0;
            O_param_update <= 1'b0;
        end else begin
            shadow         <= shadow_nxt;
            if (apply) begin
                active <= shadow;
            end
            O_param_update <= apply;
            commit_pend    <= commit_wr || (commit_pend && !apply);
        end
    end

    // Registered read port
    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            cfg_rdata    <= '0;
            cfg_rd_valid <= 1'b0;
        end else begin
            cfg_rd_valid <= cfg_rd_en;
            if (cfg_rd_en) begin
                cfg_rdata <= rd_mux;
            end
        end
    end

    assign O_blc_offset   = {active.blc3, active.blc2, active.blc1, active.blc0};
    assign O_gamma_10x    = active.gamma;
    assign O_sat_val      = active.sat;
    assign O_contrast     = active.con;
    assign O_bright_add   = active.badd;
    assign O_bright_minus = active.bsub;
    assign O_bypass       = active.bypass;

endmodule
